// File: rtl/wb_burst_ram_if.sv
// ---------------------------------------------------------------------------
// wb_burst_ram_if
// Wishbone B4 registered-feedback bus bundle between the arbiter slave port
// and wb_burst_ram. Signal names keep the slave-side view (_i into the RAM,
// _o out of the RAM).
//   wb_cyc_i   bus cycle valid          wb_stb_i   beat strobe
//   wb_addr_i  word address [31:2]      wb_cti_i   cycle type
//   wb_bte_i   burst wrap type          wb_sel_i   byte-lane enables
//   wb_we_i    1 = write                wb_data_i  write data
//   wb_data_o  read data                wb_ack_o   beat acknowledge
// ---------------------------------------------------------------------------
interface wb_burst_ram_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:2] wb_addr_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic [31:0] wb_data_i;
  logic [31:0] wb_data_o;
  logic        wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_addr_i, wb_cti_i, wb_bte_i,
           wb_sel_i, wb_we_i, wb_data_i,
    input  wb_data_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_addr_i, wb_cti_i, wb_bte_i,
           wb_sel_i, wb_we_i, wb_data_i,
    output wb_data_o, wb_ack_o
  );
endinterface

// File: rtl/wb_burst_ram.sv
// ---------------------------------------------------------------------------
// wb_burst_ram
// On-chip block-RAM Wishbone slave (2^ADDR_BITS x 32 bit). Serves classic
// single accesses (ack for one cycle, then a mandatory idle cycle) and
// registered-feedback bursts (constant, linear incrementing, wrap-4/8/16) at
// one beat per clock after a one-cycle initial latency. Only the low
// ADDR_BITS word-address bits are decoded.
// Ports:
//   wb_clk  system clock, rising edge
//   wb_rst  asynchronous active-high reset
//   wb      slave modport of wb_burst_ram_if (cyc/stb/addr/cti/bte/sel/we/
//           data in, registered data out, ack out)
// ---------------------------------------------------------------------------
module wb_burst_ram #(
  parameter int ADDR_BITS = 10
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  wb_burst_ram_if.slave wb
);

  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [2:0] CTI_CONST = 3'b001;
  localparam logic [2:0] CTI_INCR  = 3'b010;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;

  typedef logic [ADDR_BITS-1:0] addr_t;

  localparam addr_t ADDR_ONE = addr_t'(1);
  localparam addr_t MASK4    = addr_t'(3);
  localparam addr_t MASK8    = addr_t'(7);
  localparam addr_t MASK16   = addr_t'(15);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIC,
    ST_BURST
  } state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  addr_t       r_beat_addr;
  logic [31:0] r_data_o;
  logic [31:0] r_mem [DEPTH];

  addr_t       w_in_addr;
  addr_t       w_inc_addr;
  addr_t       w_next_addr;
  addr_t       w_rd_addr;
  logic [31:0] w_wr_merged;
  logic        w_req;
  logic        w_ack;
  logic        w_wr;
  logic        w_burst_cti;
  logic        w_rd_en;
  logic        w_ld_addr;
  logic        w_adv;
  logic        w_bypass;
  logic        w_unused;

  assign w_req       = wb.wb_cyc_i & wb.wb_stb_i;
  // Ack is gated by the live request so it can never appear (and no write can
  // commit) once the master drops cyc/stb, even before the next edge.
  assign w_ack       = (r_state != ST_IDLE) & w_req;
  assign w_wr        = w_ack & wb.wb_we_i;
  assign w_burst_cti = (wb.wb_cti_i == CTI_CONST) | (wb.wb_cti_i == CTI_INCR);
  assign w_in_addr   = wb.wb_addr_i[ADDR_BITS+1:2];
  assign w_inc_addr  = r_beat_addr + ADDR_ONE;

  // Upper address bits belong to the arbiter's decode.
  assign w_unused = ^wb.wb_addr_i[31:ADDR_BITS+2];

  // Next beat address: wrap modes increment only the low bits and hold the rest.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    w_next_addr = r_beat_addr;
    if (wb.wb_cti_i == CTI_INCR) begin
      case (wb.wb_bte_i)
        BTE_LINEAR: w_next_addr = w_inc_addr;
        BTE_WRAP4:  w_next_addr = (r_beat_addr & ~MASK4) | (w_inc_addr & MASK4);
        BTE_WRAP8:  w_next_addr = (r_beat_addr & ~MASK8) | (w_inc_addr & MASK8);
        default:    w_next_addr = (r_beat_addr & ~MASK16) | (w_inc_addr & MASK16);
      endcase
    end
  end

  // In a burst r_data_o always mirrors mem[r_beat_addr], so the write-first
  // word for a same-address read is built from it without a second read port.
  always_comb begin
    w_wr_merged = r_data_o;
    for (int b = 0; b < 4; b++) begin
      if (wb.wb_sel_i[b]) w_wr_merged[8*b +: 8] = wb.wb_data_i[8*b +: 8];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_rd_addr   = r_beat_addr;
    w_ld_addr   = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_rd_en     = 1'b1;
          w_rd_addr   = w_in_addr;
          w_ld_addr   = 1'b1;
          w_state_nxt = w_burst_cti ? ST_BURST : ST_CLASSIC;
        end
      end
      ST_CLASSIC: begin
        w_state_nxt = ST_IDLE;
      end
      ST_BURST: begin
        if (!wb.wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_ack) begin
          if (w_burst_cti) begin
            w_adv     = 1'b1;
            w_rd_en   = 1'b1;
            w_rd_addr = w_next_addr;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_bypass = w_wr & (w_rd_addr == r_beat_addr);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state     <= ST_IDLE;
      r_beat_addr <= '0;
      r_data_o    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_addr)    r_beat_addr <= w_in_addr;
      else if (w_adv)   r_beat_addr <= w_next_addr;
      if (w_rd_en)      r_data_o    <= w_bypass ? w_wr_merged : r_mem[w_rd_addr];
    end
  end

  // NOTE: the RAM array has no reset; contents survive wb_rst and the block
  // maps onto block RAM. Writes are still blocked in reset because w_ack
  // depends on r_state, which is held in ST_IDLE.
  always_ff @(posedge wb_clk) begin
    if (w_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wb.wb_sel_i[b]) r_mem[r_beat_addr][8*b +: 8] <= wb.wb_data_i[8*b +: 8];
      end
    end
  end

  assign wb.wb_data_o = r_data_o;
  assign wb.wb_ack_o  = w_ack;

endmodule

// File: tb/tb_wb_burst_ram.sv
// ---------------------------------------------------------------------------
// tb_wb_burst_ram
// Directed testbench for wb_burst_ram: classic access, back-to-back classic,
// linear/wrap bursts, wait states, constant burst write-first, abort and
// asynchronous reset mid-burst.
// ---------------------------------------------------------------------------
module tb_wb_burst_ram;

  logic wb_clk = 1'b0;
  logic wb_rst = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wdata    [16];
  logic [31:0] cap_data [17];
  logic        cap_ack  [17];

  wb_burst_ram_if bus ();

  wb_burst_ram #(.ADDR_BITS(10)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .wb     (bus)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers (no checking) ------------------------------------
  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.wb_cyc_i  = 1'b0;
    bus.wb_stb_i  = 1'b0;
    bus.wb_we_i   = 1'b0;
    bus.wb_addr_i = '0;
    bus.wb_cti_i  = 3'b000;
    bus.wb_bte_i  = 2'b00;
    bus.wb_sel_i  = 4'h0;
    bus.wb_data_i = '0;
  endtask

  task automatic drive(input logic [29:0] addr, input logic we, input logic [2:0] cti,
                       input logic [1:0] bte, input logic [3:0] sel, input logic [31:0] data);
    bus.wb_cyc_i  = 1'b1;
    bus.wb_stb_i  = 1'b1;
    bus.wb_addr_i = addr;
    bus.wb_we_i   = we;
    bus.wb_cti_i  = cti;
    bus.wb_bte_i  = bte;
    bus.wb_sel_i  = sel;
    bus.wb_data_i = data;
  endtask

  task automatic wr(input logic [29:0] addr, input logic [31:0] data);
    drive(addr, 1'b1, 3'b000, 2'b00, 4'hF, data);
    step();
    step();
    idle_bus();
  endtask

  task automatic rd(input logic [29:0] addr, output logic [31:0] d, output logic a);
    drive(addr, 1'b0, 3'b000, 2'b00, 4'hF, 32'h0);
    step();
    #1;
    d = bus.wb_data_o;
    a = bus.wb_ack_o;
    step();
    idle_bus();
  endtask

  // Burst of n beats; write data per beat from wdata[]. Captures data/ack of
  // each beat window plus the ack of the window after the last beat.
  task automatic run_burst(input logic [29:0] addr, input logic we, input logic [2:0] cti,
                           input logic [1:0] bte, input logic [3:0] sel, input int n);
    drive(addr, we, cti, bte, sel, wdata[0]);
    for (int i = 0; i < n; i++) begin
      step();
      #1;
      cap_data[i] = bus.wb_data_o;
      cap_ack[i]  = bus.wb_ack_o;
      bus.wb_data_i = wdata[i];
      if (i == n - 1) bus.wb_cti_i = 3'b111;
    end
    step();
    #1;
    cap_ack[n] = bus.wb_ack_o;
    idle_bus();
  endtask

  // ---- tests ---------------------------------------------------------------
  task automatic test_reset();
    idle_bus();
    wb_rst = 1'b1;
    #2;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL reset_ack: got %b expected 0", bus.wb_ack_o); end
    n_checks++; if (bus.wb_data_o !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h expected 00000000", bus.wb_data_o); end
    step();
    wb_rst = 1'b0;
    step();
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL post_reset_ack: got %b expected 0", bus.wb_ack_o); end
  endtask

  task automatic test_classic();
    logic [31:0] d;
    logic        a;
    // Full write; ack for one cycle, then the gap even with request held.
    drive(30'h010, 1'b1, 3'b000, 2'b00, 4'hF, 32'hDEADBEEF);
    #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL classic_wr_pre_ack: got %b expected 0", bus.wb_ack_o); end
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1) begin n_errors++; $display("FAIL classic_wr_ack: got %b expected 1", bus.wb_ack_o); end
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL classic_wr_gap: got %b expected 0", bus.wb_ack_o); end
    idle_bus();

    rd(30'h010, d, a);
    n_checks++; if (a !== 1'b1) begin n_errors++; $display("FAIL classic_rd_ack: got %b expected 1", a); end
    n_checks++; if (d !== 32'hDEADBEEF) begin n_errors++; $display("FAIL classic_rd_data: got %h expected deadbeef", d); end

    // Byte lane 1 only.
    drive(30'h010, 1'b1, 3'b000, 2'b00, 4'b0010, 32'h0000AA00);
    step(); step(); idle_bus();
    rd(30'h010, d, a);
    n_checks++; if (d !== 32'hDEADAAEF) begin n_errors++; $display("FAIL classic_sel_data: got %h expected deadaaef", d); end

    // sel 0000: ack but no change.
    drive(30'h010, 1'b1, 3'b000, 2'b00, 4'b0000, 32'hFFFFFFFF);
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1) begin n_errors++; $display("FAIL classic_sel0_ack: got %b expected 1", bus.wb_ack_o); end
    step(); idle_bus();
    rd(30'h010, d, a);
    n_checks++; if (d !== 32'hDEADAAEF) begin n_errors++; $display("FAIL classic_sel0_data: got %h expected deadaaef", d); end

    // Upper address bits ignored.
    rd(30'h2000_0010, d, a);
    n_checks++; if (d !== 32'hDEADAAEF) begin n_errors++; $display("FAIL classic_upper_addr: got %h expected deadaaef", d); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive(30'h010, 1'b0, 3'b000, 2'b00, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      n_checks++; if (bus.wb_ack_o !== exp_ack[i]) begin n_errors++; $display("FAIL b2b_ack[%0d]: got %b expected %b", i, bus.wb_ack_o, exp_ack[i]); end
      if (exp_ack[i]) begin
        n_checks++; if (bus.wb_data_o !== 32'hDEADAAEF) begin n_errors++; $display("FAIL b2b_data[%0d]: got %h expected deadaaef", i, bus.wb_data_o); end
      end
    end
    idle_bus();
  endtask

  task automatic test_incr_burst();
    logic [31:0] exp_d [3] = '{32'hA5A5_03FE, 32'hB6B6_03FF, 32'hC7C7_0000};
    wr(30'h3FE, 32'hA5A5_03FE);
    wr(30'h3FF, 32'hB6B6_03FF);
    wr(30'h000, 32'hC7C7_0000);
    run_burst(30'h3FE, 1'b0, 3'b010, 2'b00, 4'hF, 3);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (cap_ack[i] !== 1'b1) begin n_errors++; $display("FAIL incr_ack[%0d]: got %b expected 1", i, cap_ack[i]); end
      n_checks++; if (cap_data[i] !== exp_d[i]) begin n_errors++; $display("FAIL incr_data[%0d]: got %h expected %h", i, cap_data[i], exp_d[i]); end
    end
    n_checks++; if (cap_ack[3] !== 1'b0) begin n_errors++; $display("FAIL incr_ack_end: got %b expected 0", cap_ack[3]); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp4 [4] = '{32'h1000_0006, 32'h1000_0007, 32'h1000_0004, 32'h1000_0005};
    logic [31:0] exp8 [8] = '{32'h1000_000E, 32'h1000_000F, 32'h1000_0008, 32'h1000_0009,
                              32'h1000_000A, 32'h1000_000B, 32'h1000_000C, 32'h1000_000D};
    for (int a = 4; a < 16; a++) wr(30'(a), 32'h1000_0000 | 32'(a));

    run_burst(30'h006, 1'b0, 3'b010, 2'b01, 4'hF, 4);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (cap_data[i] !== exp4[i] || cap_ack[i] !== 1'b1) begin n_errors++; $display("FAIL wrap4[%0d]: got %h ack %b expected %h ack 1", i, cap_data[i], cap_ack[i], exp4[i]); end
    end
    n_checks++; if (cap_ack[4] !== 1'b0) begin n_errors++; $display("FAIL wrap4_end: got %b expected 0", cap_ack[4]); end

    run_burst(30'h00E, 1'b0, 3'b010, 2'b10, 4'hF, 8);
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (cap_data[i] !== exp8[i] || cap_ack[i] !== 1'b1) begin n_errors++; $display("FAIL wrap8[%0d]: got %h ack %b expected %h ack 1", i, cap_data[i], cap_ack[i], exp8[i]); end
    end
    n_checks++; if (cap_ack[8] !== 1'b0) begin n_errors++; $display("FAIL wrap8_end: got %b expected 0", cap_ack[8]); end
  endtask

  task automatic test_wait_state();
    // 4-beat linear read of words 0x004..0x007, stb low for 2 cycles after beat 2.
    drive(30'h004, 1'b0, 3'b010, 2'b00, 4'hF, 32'h0);
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h1000_0004) begin n_errors++; $display("FAIL wait_beat1: got %h ack %b expected 10000004 ack 1", bus.wb_data_o, bus.wb_ack_o); end
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h1000_0005) begin n_errors++; $display("FAIL wait_beat2: got %h ack %b expected 10000005 ack 1", bus.wb_data_o, bus.wb_ack_o); end
    step();
    bus.wb_stb_i = 1'b0;
    #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0 || bus.wb_data_o !== 32'h1000_0006) begin n_errors++; $display("FAIL wait_hold1: got %h ack %b expected 10000006 ack 0", bus.wb_data_o, bus.wb_ack_o); end
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0 || bus.wb_data_o !== 32'h1000_0006) begin n_errors++; $display("FAIL wait_hold2: got %h ack %b expected 10000006 ack 0", bus.wb_data_o, bus.wb_ack_o); end
    bus.wb_stb_i = 1'b1;
    #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h1000_0006) begin n_errors++; $display("FAIL wait_beat3: got %h ack %b expected 10000006 ack 1", bus.wb_data_o, bus.wb_ack_o); end
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h1000_0007) begin n_errors++; $display("FAIL wait_beat4: got %h ack %b expected 10000007 ack 1", bus.wb_data_o, bus.wb_ack_o); end
    bus.wb_cti_i = 3'b111;
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL wait_end: got %b expected 0", bus.wb_ack_o); end
    idle_bus();
  endtask

  task automatic test_const_burst();
    logic [31:0] d;
    logic        a;
    wr(30'h020, 32'h1111_1111);
    // Beat 1 writes low half; beat 2 reads the same word back.
    drive(30'h020, 1'b1, 3'b001, 2'b00, 4'b0011, 32'h0000_F00D);
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h1111_1111) begin n_errors++; $display("FAIL const_beat1: got %h ack %b expected 11111111 ack 1", bus.wb_data_o, bus.wb_ack_o); end
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h1111_F00D) begin n_errors++; $display("FAIL const_write_first: got %h ack %b expected 1111f00d ack 1", bus.wb_data_o, bus.wb_ack_o); end
    bus.wb_we_i  = 1'b0;
    bus.wb_cti_i = 3'b111;
    step(); #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL const_end: got %b expected 0", bus.wb_ack_o); end
    idle_bus();
    rd(30'h020, d, a);
    n_checks++; if (d !== 32'h1111_F00D) begin n_errors++; $display("FAIL const_mem: got %h expected 1111f00d", d); end
  endtask

  task automatic test_abort();
    logic [31:0] d;
    logic        a;
    wr(30'h042, 32'h0AA0_0042);
    wr(30'h043, 32'h0AA0_0043);
    drive(30'h040, 1'b1, 3'b010, 2'b00, 4'hF, 32'h5000_0000);
    step();
    step(); bus.wb_data_i = 32'h5000_0001;
    step(); bus.wb_data_i = 32'h5000_0002;
    #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1) begin n_errors++; $display("FAIL abort_pre_ack: got %b expected 1", bus.wb_ack_o); end
    bus.wb_cyc_i = 1'b0;
    #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL abort_ack_drop: got %b expected 0", bus.wb_ack_o); end
    step();
    idle_bus();
    rd(30'h040, d, a);
    n_checks++; if (d !== 32'h5000_0000) begin n_errors++; $display("FAIL abort_mem40: got %h expected 50000000", d); end
    rd(30'h041, d, a);
    n_checks++; if (d !== 32'h5000_0001) begin n_errors++; $display("FAIL abort_mem41: got %h expected 50000001", d); end
    rd(30'h042, d, a);
    n_checks++; if (d !== 32'h0AA0_0042) begin n_errors++; $display("FAIL abort_mem42: got %h expected 0aa00042", d); end
    rd(30'h043, d, a);
    n_checks++; if (d !== 32'h0AA0_0043) begin n_errors++; $display("FAIL abort_mem43: got %h expected 0aa00043", d); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d;
    logic        a;
    wr(30'h052, 32'h0BB0_0052);
    drive(30'h050, 1'b1, 3'b010, 2'b00, 4'hF, 32'h6000_0000);
    step();
    step(); bus.wb_data_i = 32'h6000_0001;
    step(); bus.wb_data_i = 32'h6000_0002;
    #1;
    n_checks++; if (bus.wb_ack_o !== 1'b1 || bus.wb_data_o !== 32'h0BB0_0052) begin n_errors++; $display("FAIL rstmid_pre: got %h ack %b expected 0bb00052 ack 1", bus.wb_data_o, bus.wb_ack_o); end
    wb_rst = 1'b1;
    #1;
    n_checks++; if (bus.wb_ack_o !== 1'b0) begin n_errors++; $display("FAIL rstmid_ack: got %b expected 0", bus.wb_ack_o); end
    n_checks++; if (bus.wb_data_o !== 32'h0) begin n_errors++; $display("FAIL rstmid_data: got %h expected 00000000", bus.wb_data_o); end
    step();
    #1;
    idle_bus();
    wb_rst = 1'b0;
    step();
    rd(30'h050, d, a);
    n_checks++; if (d !== 32'h6000_0000) begin n_errors++; $display("FAIL rstmid_mem50: got %h expected 60000000", d); end
    rd(30'h051, d, a);
    n_checks++; if (d !== 32'h6000_0001) begin n_errors++; $display("FAIL rstmid_mem51: got %h expected 60000001", d); end
    rd(30'h052, d, a);
    n_checks++; if (d !== 32'h0BB0_0052) begin n_errors++; $display("FAIL rstmid_mem52: got %h expected 0bb00052", d); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) wdata[i] = 32'h0;
    test_reset();
    test_classic();
    test_back_to_back();
    test_incr_burst();
    test_wrap();
    test_wait_state();
    test_const_burst();
    test_abort();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
